// File: rtl/coder_arbiter_if.sv
// Bus bundle between the requesters, the shared Golay coder and coder_arbiter.
// The arbiter attaches through the slave modport. The environment (requesters
// plus coder) attaches through the master modport.
interface coder_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req;
  logic [12*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ack;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [23:0]           rsp_code;
  logic                  rsp_err;
  logic                  busy;
  logic                  coder_enable;
  logic [11:0]           coder_input;
  logic [23:0]           coder_output;
  logic                  coder_ready;
  logic                  coder_finish;

  modport master (
    output req, req_data, coder_output, coder_ready, coder_finish,
    input  req_ack, rsp_valid, rsp_id, rsp_code, rsp_err, busy,
           coder_enable, coder_input
  );

  modport slave (
    input  req, req_data, coder_output, coder_ready, coder_finish,
    output req_ack, rsp_valid, rsp_id, rsp_code, rsp_err, busy,
           coder_enable, coder_input
  );
endinterface

// File: rtl/coder_arbiter.sv
// Round-robin sharing of one 12->24 bit Golay coder among NUM_REQ requesters.
// The winner's word goes to the coder. When the coder finishes, the codeword is
// returned tagged with the requester id. A watchdog turns a coder that never
// finishes into an error response. Every output is registered.
module coder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  coder_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WAIT, RECOVER} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     last_grant, last_grant_next;
  logic [ID_W-1:0]     grant_id, grant_id_next;
  logic [ID_W-1:0]     winner;
  logic [7:0]          wdog, wdog_next;
  logic [NUM_REQ-1:0]  req_ack, req_ack_next;
  logic                coder_enable, coder_enable_next;
  logic [11:0]         coder_input, coder_input_next;
  logic                rsp_valid, rsp_valid_next;
  logic [ID_W-1:0]     rsp_id, rsp_id_next;
  logic [23:0]         rsp_code, rsp_code_next;
  logic                rsp_err, rsp_err_next;
  logic                busy, busy_next;

  // First set request found scanning upward from the slot after the last grant.
  // The loop runs from the far end down, so the nearest candidate is assigned last and wins.
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                           input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] w;
    int              idx;
    w = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (r[idx]) w = ID_W'(idx);
    end
    return w;
  endfunction

  assign winner = pick(bus.req, last_grant);

  assign bus.req_ack      = req_ack;
  assign bus.coder_enable = coder_enable;
  assign bus.coder_input  = coder_input;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_id       = rsp_id;
  assign bus.rsp_code     = rsp_code;
  assign bus.rsp_err      = rsp_err;
  assign bus.busy         = busy;

  // State and registered outputs. Reset aborts any in-flight word and restores req 0 priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= ID_W'(NUM_REQ - 1);
      grant_id     <= '0;
      wdog         <= '0;
      req_ack      <= '0;
      coder_enable <= 1'b0;
      coder_input  <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_code     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      last_grant   <= last_grant_next;
      grant_id     <= grant_id_next;
      wdog         <= wdog_next;
      req_ack      <= req_ack_next;
      coder_enable <= coder_enable_next;
      coder_input  <= coder_input_next;
      rsp_valid    <= rsp_valid_next;
      rsp_id       <= rsp_id_next;
      rsp_code     <= rsp_code_next;
      rsp_err      <= rsp_err_next;
      busy         <= busy_next;
    end
  end

  // Next state and next outputs. The ack, enable and valid signals default low, which makes them one-cycle pulses.
  always_comb begin
    state_next        = state;
    last_grant_next   = last_grant;
    grant_id_next     = grant_id;
    wdog_next         = wdog;
    req_ack_next      = '0;
    coder_enable_next = 1'b0;
    coder_input_next  = coder_input;
    rsp_valid_next    = 1'b0;
    rsp_id_next       = rsp_id;
    rsp_code_next     = rsp_code;
    rsp_err_next      = rsp_err;

    case (state)
      IDLE: begin
        // A finish still high here is stale, so wait until the coder is clean.
        if (|bus.req && bus.coder_ready && !bus.coder_finish) begin
          coder_input_next     = bus.req_data[12*winner +: 12];
          coder_enable_next    = 1'b1;
          req_ack_next[winner] = 1'b1;
          grant_id_next        = winner;
          last_grant_next      = winner;
          wdog_next            = '0;
          state_next           = WAIT;
        end
      end
      WAIT: begin
        if (bus.coder_finish) begin
          rsp_code_next  = bus.coder_output;
          rsp_id_next    = grant_id;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RECOVER;
        end else begin
          wdog_next = wdog + 8'd1;
          if (wdog == 8'(TIMEOUT - 1)) begin
            rsp_code_next  = '0;
            rsp_id_next    = grant_id;
            rsp_err_next   = 1'b1;
            rsp_valid_next = 1'b1;
            state_next     = IDLE;
          end
        end
      end
      RECOVER: begin
        if (bus.coder_ready && !bus.coder_finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end
endmodule
